// File: rtl/axi_lite_cfg_pkg.sv
// axi_lite_cfg_pkg: shared types for the AXI4-Lite config sequencer.
// Response codes, FSM states and the registered command bundle.
package axi_lite_cfg_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } state_e;

  typedef struct packed {
    logic              write;
    logic              check;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_data;
  } cmd_t;

  // States in which the sequencer is blocked on the slave.
  function automatic logic is_wait(state_e s);
    return s inside {WR_AW_W, WR_B, RD_AR, RD_R};
  endfunction

endpackage

// File: rtl/axi_lite_cfg_sequencer_if.sv
// axi_lite_cfg_sequencer_if: command/response port plus AXI4-Lite master bus.
// master = sequencer side, slave = command source + AXI slave side.
interface axi_lite_cfg_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic                    cmd_check;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH-1:0]   cmd_expect;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_resp;
  logic                    rsp_mismatch;

  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]              M_AXI_AWPROT;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]              M_AXI_ARPROT;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_check,
    input  cmd_addr, cmd_wdata, cmd_expect,
    output cmd_ready,
    output rsp_valid, rsp_rdata,
    output rsp_resp, rsp_mismatch,
    input  rsp_ready,
    output M_AXI_AWADDR, M_AXI_AWPROT,
    output M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP,
    input  M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_check,
    output cmd_addr, cmd_wdata, cmd_expect,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata,
    input  rsp_resp, rsp_mismatch,
    output rsp_ready,
    input  M_AXI_AWADDR, M_AXI_AWPROT,
    input  M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP,
    output M_AXI_RVALID,
    input  M_AXI_RREADY
  );

endinterface

// File: rtl/axi_lite_sat_cnt.sv
// axi_lite_sat_cnt: counter that increments on inc and holds at all-ones.
// Ports: clk, rst (sync, active-high), inc, cnt.
module axi_lite_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/axi_lite_cfg_sequencer.sv
// axi_lite_cfg_sequencer: single-beat AXI4-Lite master for regmap bring-up.
// Ports: ACLK, ARESET, bus (cmd/rsp + AXI), pass_cnt, fail_cnt, stall_flag.
module axi_lite_cfg_sequencer
  import axi_lite_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int DATA_WIDTH   = DATA_W,
  parameter int STALL_CYCLES = 256
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  axi_lite_cfg_sequencer_if.master bus,
  output logic [15:0]              pass_cnt,
  output logic [15:0]              fail_cnt,
  output logic                     stall_flag
);

  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  state_e          state;
  state_e          state_nx;
  cmd_t            cmd_q;
  logic            aw_done;
  logic            w_done;
  logic [DATA_W-1:0] rdata_q;
  resp_e           resp_q;
  logic            mis_q;
  logic [SW-1:0]   stall_cnt;

  logic accept;
  logic aw_hs;
  logic w_hs;
  logic wr_done;
  logic rd_done;
  logic rd_mis;
  logic bad_resp;
  logic pass_inc;
  logic fail_inc;

  // Ready only once out of reset so nothing is taken mid-reset.
  assign bus.cmd_ready = (state == IDLE) & ~ARESET;
  assign accept  = bus.cmd_valid & bus.cmd_ready;

  assign aw_hs   = (state == WR_AW_W) & ~aw_done
                 & bus.M_AXI_AWREADY;
  assign w_hs    = (state == WR_AW_W) & ~w_done
                 & bus.M_AXI_WREADY;
  assign wr_done = (state == WR_B) & bus.M_AXI_BVALID;
  assign rd_done = (state == RD_R) & bus.M_AXI_RVALID;

  assign rd_mis  = cmd_q.check & ~cmd_q.write
                 & (bus.M_AXI_RDATA != cmd_q.exp_data);

  assign bad_resp = wr_done
                  ? (bus.M_AXI_BRESP != OKAY)
                  : (bus.M_AXI_RRESP != OKAY);

  // Both fire only on the edge that enters RSP.
  assign pass_inc = rd_done & cmd_q.check & ~rd_mis
                  & (bus.M_AXI_RRESP == OKAY);
  assign fail_inc = (wr_done | rd_done)
                  & ((rd_done & rd_mis) | bad_resp);

  assign bus.M_AXI_AWADDR = cmd_q.addr;
  assign bus.M_AXI_ARADDR = cmd_q.addr;
  assign bus.M_AXI_WDATA  = cmd_q.wdata;
  assign bus.M_AXI_WSTRB  = '1;
  assign bus.M_AXI_AWPROT = 3'b000;
  assign bus.M_AXI_ARPROT = 3'b000;

  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_resp     = resp_q;
  assign bus.rsp_mismatch = mis_q;

  always_comb begin
    state_nx          = state;
    bus.M_AXI_AWVALID = 1'b0;
    bus.M_AXI_WVALID  = 1'b0;
    bus.M_AXI_BREADY  = 1'b0;
    bus.M_AXI_ARVALID = 1'b0;
    bus.M_AXI_RREADY  = 1'b0;
    bus.rsp_valid     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = bus.cmd_write ? WR_AW_W : RD_AR;
        end
      end
      WR_AW_W: begin
        bus.M_AXI_AWVALID = ~aw_done;
        bus.M_AXI_WVALID  = ~w_done;
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          state_nx = WR_B;
        end
      end
      WR_B: begin
        bus.M_AXI_BREADY = 1'b1;
        if (bus.M_AXI_BVALID) state_nx = RSP;
      end
      RD_AR: begin
        bus.M_AXI_ARVALID = 1'b1;
        if (bus.M_AXI_ARREADY) state_nx = RD_R;
      end
      RD_R: begin
        bus.M_AXI_RREADY = 1'b1;
        if (bus.M_AXI_RVALID) state_nx = RSP;
      end
      RSP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      cmd_q      <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rdata_q    <= '0;
      resp_q     <= OKAY;
      mis_q      <= 1'b0;
      stall_cnt  <= '0;
      stall_flag <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cmd_q.write    <= bus.cmd_write;
        cmd_q.check    <= bus.cmd_check;
        cmd_q.addr     <= bus.cmd_addr & ALIGN;
        cmd_q.wdata    <= bus.cmd_wdata;
        cmd_q.exp_data <= bus.cmd_expect;
        aw_done        <= 1'b0;
        w_done         <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (wr_done) begin
        rdata_q <= '0;
        resp_q  <= resp_e'(bus.M_AXI_BRESP);
        mis_q   <= 1'b0;
      end
      if (rd_done) begin
        rdata_q <= bus.M_AXI_RDATA;
        resp_q  <= resp_e'(bus.M_AXI_RRESP);
        mis_q   <= rd_mis;
      end
      // Per-state wait timer; saturates, never aborts.
      if (state_nx != state) begin
        stall_cnt <= '0;
      end else if (is_wait(state) &&
                   stall_cnt != SW'(STALL_CYCLES)) begin
        stall_cnt <= stall_cnt + SW'(1);
        if (stall_cnt == SW'(STALL_CYCLES - 1)) begin
          stall_flag <= 1'b1;
        end
      end
    end
  end

  axi_lite_sat_cnt #(.WIDTH(16)) u_pass_cnt (
    .clk (ACLK),
    .rst (ARESET),
    .inc (pass_inc),
    .cnt (pass_cnt)
  );

  axi_lite_sat_cnt #(.WIDTH(16)) u_fail_cnt (
    .clk (ACLK),
    .rst (ARESET),
    .inc (fail_inc),
    .cnt (fail_cnt)
  );

endmodule

// File: tb/tb_axi_lite_cfg_sequencer.sv
// tb_axi_lite_cfg_sequencer: sequencer driving a 4-register regmap model.
// Directed steps with a response scoreboard and gated slave readies.
module tb_axi_lite_cfg_sequencer;

  logic        ACLK;
  logic        ARESET;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic        stall_flag;

  axi_lite_cfg_sequencer_if #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32)
  ) bus ();

  axi_lite_cfg_sequencer #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .STALL_CYCLES(256)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .bus        (bus.master),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .stall_flag (stall_flag)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Slave-side controls.
  logic aw_en, w_en, ar_en, rnd_mode, b_hold, err8;
  logic aw_r, w_r, ar_r;

  // Regmap model state.
  logic [31:0] regs [4];
  logic        have_aw, have_w, aw_seen, w_seen;
  logic [3:0]  aw_addr;
  logic [31:0] w_data;
  logic        bvalid, rvalid;
  logic [1:0]  bresp;
  logic [31:0] rdata;
  logic        aw_pend, w_pend, ar_pend;
  int          aw_cnt = 0;
  int          w_cnt = 0;
  int          drop_err = 0;
  int          bready_early = 0;

  assign bus.M_AXI_AWREADY = aw_en & (~rnd_mode | aw_r);
  assign bus.M_AXI_WREADY  = w_en  & (~rnd_mode | w_r);
  assign bus.M_AXI_ARREADY = ar_en & (~rnd_mode | ar_r);
  assign bus.M_AXI_BVALID  = bvalid;
  assign bus.M_AXI_BRESP   = bresp;
  assign bus.M_AXI_RVALID  = rvalid;
  assign bus.M_AXI_RDATA   = rdata;
  assign bus.M_AXI_RRESP   = 2'd0;

  always @(posedge ACLK) begin
    aw_r <= 1'($urandom);
    w_r  <= 1'($urandom);
    ar_r <= 1'($urandom);
    if (ARESET) begin
      have_aw <= 1'b0;
      have_w  <= 1'b0;
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      bvalid  <= 1'b0;
      bresp   <= 2'd0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      ar_pend <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      // A VALID dropped before its READY breaks the AXI rule.
      if (aw_pend && !bus.M_AXI_AWVALID) drop_err <= drop_err + 1;
      if (w_pend && !bus.M_AXI_WVALID) drop_err <= drop_err + 1;
      if (ar_pend && !bus.M_AXI_ARVALID) drop_err <= drop_err + 1;
      aw_pend <= bus.M_AXI_AWVALID & ~bus.M_AXI_AWREADY;
      w_pend  <= bus.M_AXI_WVALID & ~bus.M_AXI_WREADY;
      ar_pend <= bus.M_AXI_ARVALID & ~bus.M_AXI_ARREADY;
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        have_aw <= 1'b1;
        aw_seen <= 1'b1;
        aw_addr <= bus.M_AXI_AWADDR;
        aw_cnt  <= aw_cnt + 1;
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        have_w <= 1'b1;
        w_seen <= 1'b1;
        w_data <= bus.M_AXI_WDATA;
        w_cnt  <= w_cnt + 1;
      end
      if (have_aw && have_w && !bvalid && !b_hold) begin
        bvalid  <= 1'b1;
        have_aw <= 1'b0;
        have_w  <= 1'b0;
        if (err8 && aw_addr == 4'h8) begin
          bresp <= 2'd2;
        end else begin
          bresp <= 2'd0;
          regs[aw_addr[3:2]] <= w_data;
        end
      end
      if (bus.M_AXI_BREADY && !(aw_seen && w_seen)) begin
        bready_early <= bready_early + 1;
      end
      if (bvalid && bus.M_AXI_BREADY) begin
        bvalid  <= 1'b0;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        rvalid <= 1'b1;
        rdata  <= regs[bus.M_AXI_ARADDR[3:2]];
      end
      if (rvalid && bus.M_AXI_RREADY) rvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic ck,
                       input logic [3:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] ex,
                       input exp_t e);
    int t;
    t = 0;
    sb.push_back(e);
    @(negedge ACLK);
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = wr;
    bus.cmd_check  = ck;
    bus.cmd_addr   = a;
    bus.cmd_wdata  = wd;
    bus.cmd_expect = ex;
    while (!bus.cmd_ready && t < 50) begin
      @(negedge ACLK);
      t++;
    end
    chk("cmd_accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge ACLK);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic collect(input string tag, output int lat);
    exp_t e;
    int   t;
    t = 1;
    @(negedge ACLK);
    while (!bus.rsp_valid && t < 600) begin
      @(negedge ACLK);
      t++;
    end
    lat = t;
    chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '0;
    chk({tag, ".rdata"}, bus.rsp_rdata, e.rdata);
    chk({tag, ".resp"}, 32'(bus.rsp_resp), 32'(e.resp));
    chk({tag, ".mis"}, 32'(bus.rsp_mismatch), 32'(e.mis));
    bus.rsp_ready = 1'b1;
    @(posedge ACLK);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int a0;
    int w0;
    int t;
    ARESET = 1'b1;
    aw_en = 1'b1; w_en = 1'b1; ar_en = 1'b1;
    rnd_mode = 1'b0; b_hold = 1'b0; err8 = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
    bus.cmd_check = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_expect = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge ACLK);

    chk("rst.cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst.awvalid", 32'(bus.M_AXI_AWVALID), 0);
    chk("rst.wvalid", 32'(bus.M_AXI_WVALID), 0);
    chk("rst.arvalid", 32'(bus.M_AXI_ARVALID), 0);
    chk("rst.bready", 32'(bus.M_AXI_BREADY), 0);
    chk("rst.rready", 32'(bus.M_AXI_RREADY), 0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst.rsp_rdata", bus.rsp_rdata, 0);
    chk("rst.awaddr", 32'(bus.M_AXI_AWADDR), 0);
    chk("rst.wdata", bus.M_AXI_WDATA, 0);
    chk("rst.wstrb", 32'(bus.M_AXI_WSTRB), 32'hF);
    chk("rst.prot", 32'({bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}), 0);
    chk("rst.pass", 32'(pass_cnt), 0);
    chk("rst.fail", 32'(fail_cnt), 0);
    chk("rst.stall", 32'(stall_flag), 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rel.cmd_ready", 32'(bus.cmd_ready), 1);

    // 1: fill all four regs, read them back checked.
    rnd_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, 4'(i * 4), 32'(i + 1), 0,
            '{32'd0, 2'd0, 1'b0});
      collect("s1.wr", lat);
    end
    rnd_mode = 1'b0;
    issue(1'b0, 1'b1, 4'h0, 0, 32'h1, '{32'h1, 2'd0, 1'b0});
    collect("s1.rd0", lat);
    chk("s1.rd_latency", 32'(lat), 32'd3);
    rnd_mode = 1'b1;
    for (int i = 1; i < 4; i++) begin
      issue(1'b0, 1'b1, 4'(i * 4), 0, 32'(i + 1),
            '{32'(i + 1), 2'd0, 1'b0});
      collect("s1.rd", lat);
    end
    chk("s1.pass", 32'(pass_cnt), 4);
    chk("s1.fail", 32'(fail_cnt), 0);

    // 2: checked read with wrong expectation.
    issue(1'b0, 1'b1, 4'h4, 0, 32'hDEADBEEF,
          '{32'h2, 2'd0, 1'b1});
    collect("s2.rd", lat);
    chk("s2.pass", 32'(pass_cnt), 4);
    chk("s2.fail", 32'(fail_cnt), 1);

    // 3: SLVERR on write to 0x8; unaligned address still hits 0x8.
    err8 = 1'b1;
    issue(1'b1, 1'b0, 4'hA, 32'h33, 0, '{32'd0, 2'd2, 1'b0});
    collect("s3.wr", lat);
    err8 = 1'b0;
    chk("s3.fail", 32'(fail_cnt), 2);
    @(negedge ACLK);
    chk("s3.idle", 32'(bus.cmd_ready), 1);
    issue(1'b0, 1'b1, 4'h8, 0, 32'h3, '{32'h3, 2'd0, 1'b0});
    collect("s3.rd", lat);
    chk("s3.pass", 32'(pass_cnt), 5);

    // 4: W before AW, then both together, then AW before W.
    rnd_mode = 1'b0;
    aw_en = 1'b0; w_en = 1'b1;
    a0 = aw_cnt; w0 = w_cnt;
    issue(1'b1, 1'b0, 4'h4, 32'h44, 0, '{32'd0, 2'd0, 1'b0});
    repeat (5) @(negedge ACLK);
    chk("s4a.w_cnt", 32'(w_cnt - w0), 1);
    chk("s4a.aw_cnt", 32'(aw_cnt - a0), 0);
    chk("s4a.bready", 32'(bus.M_AXI_BREADY), 0);
    aw_en = 1'b1;
    collect("s4a.wr", lat);
    chk("s4a.aw_tot", 32'(aw_cnt - a0), 1);
    chk("s4a.w_tot", 32'(w_cnt - w0), 1);

    aw_en = 1'b0; w_en = 1'b0;
    a0 = aw_cnt; w0 = w_cnt;
    issue(1'b1, 1'b0, 4'hC, 32'hCC, 0, '{32'd0, 2'd0, 1'b0});
    repeat (3) @(negedge ACLK);
    chk("s4b.bready", 32'(bus.M_AXI_BREADY), 0);
    aw_en = 1'b1; w_en = 1'b1;
    collect("s4b.wr", lat);
    chk("s4b.aw_tot", 32'(aw_cnt - a0), 1);
    chk("s4b.w_tot", 32'(w_cnt - w0), 1);

    w_en = 1'b0;
    a0 = aw_cnt; w0 = w_cnt;
    issue(1'b1, 1'b0, 4'h0, 32'h10, 0, '{32'd0, 2'd0, 1'b0});
    repeat (4) @(negedge ACLK);
    chk("s4c.aw_cnt", 32'(aw_cnt - a0), 1);
    chk("s4c.bready", 32'(bus.M_AXI_BREADY), 0);
    w_en = 1'b1;
    collect("s4c.wr", lat);
    chk("s4c.w_tot", 32'(w_cnt - w0), 1);

    issue(1'b0, 1'b1, 4'h4, 0, 32'h44, '{32'h44, 2'd0, 1'b0});
    collect("s4.rd4", lat);
    issue(1'b0, 1'b1, 4'hC, 0, 32'hCC, '{32'hCC, 2'd0, 1'b0});
    collect("s4.rdC", lat);
    chk("s4.pass", 32'(pass_cnt), 7);
    chk("s4.bready_early", 32'(bready_early), 0);

    // 5: ARREADY held low for 300 cycles.
    ar_en = 1'b0;
    issue(1'b0, 1'b1, 4'h0, 0, 32'h10, '{32'h10, 2'd0, 1'b0});
    repeat (250) @(negedge ACLK);
    chk("s5.stall_early", 32'(stall_flag), 0);
    repeat (50) @(negedge ACLK);
    chk("s5.stall_set", 32'(stall_flag), 1);
    chk("s5.arvalid_held", 32'(bus.M_AXI_ARVALID), 1);
    ar_en = 1'b1;
    collect("s5.rd", lat);
    chk("s5.stall_sticky", 32'(stall_flag), 1);
    chk("s5.pass", 32'(pass_cnt), 8);

    // 6: reset while waiting for B with rsp_ready low.
    b_hold = 1'b1;
    issue(1'b1, 1'b0, 4'h0, 32'h77, 0, '{32'd0, 2'd0, 1'b0});
    t = 0;
    while (!bus.M_AXI_BREADY && t < 20) begin
      @(negedge ACLK);
      t++;
    end
    chk("s6.in_wr_b", 32'(bus.M_AXI_BREADY), 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("s6.awvalid", 32'(bus.M_AXI_AWVALID), 0);
    chk("s6.wvalid", 32'(bus.M_AXI_WVALID), 0);
    chk("s6.arvalid", 32'(bus.M_AXI_ARVALID), 0);
    chk("s6.bready", 32'(bus.M_AXI_BREADY), 0);
    chk("s6.rsp_valid", 32'(bus.rsp_valid), 0);
    chk("s6.pass", 32'(pass_cnt), 0);
    chk("s6.fail", 32'(fail_cnt), 0);
    chk("s6.stall", 32'(stall_flag), 0);
    sb.delete();
    b_hold = 1'b0;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("s6.cmd_ready", 32'(bus.cmd_ready), 1);
    issue(1'b1, 1'b0, 4'h4, 32'h55, 0, '{32'd0, 2'd0, 1'b0});
    collect("s6.wr", lat);
    issue(1'b0, 1'b1, 4'h4, 0, 32'h55, '{32'h55, 2'd0, 1'b0});
    collect("s6.rd", lat);
    chk("s6.pass_after", 32'(pass_cnt), 1);
    chk("s6.fail_after", 32'(fail_cnt), 0);

    chk("axi.valid_drop", 32'(drop_err), 0);
    chk("sb.empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
